// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// FSM state encoding, shift word width and the hex-to-segment table.
package seg_scan_driver_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Active-high segment pattern, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// CPU-side bus of the scan driver: display contents, control flags and frame status.
interface seg_scan_driver_if #(
  parameter int DIGITS = 8
);
  // en is a level request sampled only at frame boundaries; busy is high from
  // LOAD through the last latch; frame_done pulses for one cycle per completed frame.
  logic                  en;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_mask;
  logic                  lzb_en;
  logic                  blank;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output en, data, dp_mask, lzb_en, blank,
    input  busy, frame_done
  );

  modport slave (
    input  en, data, dp_mask, lzb_en, blank,
    output busy, frame_done
  );
endinterface

// File: rtl/seg_scan_driver_hex_decode.sv
// Nibble + decimal point + blank to one segment byte {dp, gfedcba}, in pin polarity.
module seg_hex_decode
  import seg_scan_driver_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_hi;

  always_comb begin
    seg_hi = blank_i ? 8'h00 : {dp_i, hex_to_seg(nibble_i)};
    seg_o  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans DIGITS hex digits out to a daisy-chained pair of 74HC595s, one
// {seg, sel} word per digit, from a snapshot taken at the start of each frame.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCLK_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_driver_if.slave bus,
  output logic             sh_cp,
  output logic             st_cp,
  output logic             ds,
  output state_e           dbg_state_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [DIG_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                lzb_q, lzb_d;
  logic                blank_q, blank_d;

  logic                sh_cp_q, st_cp_q, ds_q, busy_q, done_q;

  logic                div_last;
  logic [DIGITS-1:0]   dig_blank;
  logic                upper_zero;
  logic [7:0]          seg_byte;
  logic [7:0]          sel_hi;
  logic [7:0]          sel_byte;
  logic [WORD_W-1:0]   word_d;
  logic                ds_d;

  assign div_last = (div_cnt_q == DIV_W'(SCLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    digit_cnt_d = digit_cnt_q;
    data_d      = data_q;
    dp_d        = dp_q;
    lzb_d       = lzb_q;
    blank_d     = blank_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        data_d      = bus.data;
        dp_d        = bus.dp_mask;
        lzb_d       = bus.lzb_en;
        blank_d     = bus.blank;
        div_cnt_d   = '0;
        bit_cnt_d   = '0;
        digit_cnt_d = '0;
        state_d     = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = '0;
            state_d   = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (digit_cnt_q == DIG_W'(DIGITS - 1)) begin
            state_d = ST_DONE;
          end else begin
            digit_cnt_d = digit_cnt_q + 1'b1;
            state_d     = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = bus.en ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leading-zero blanking walks down from the top digit; digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    dig_blank  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (data_d[4*i +: 4] == 4'h0);
      dig_blank[i] = blank_d | (lzb_d & upper_zero & (i != 0));
    end
  end

  seg_hex_decode #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decode (
    .nibble_i (data_d[{digit_cnt_d, 2'b00} +: 4]),
    .dp_i     (dp_d[digit_cnt_d]),
    .blank_i  (dig_blank[digit_cnt_d]),
    .seg_o    (seg_byte)
  );

  // Pins are registered from next-state values so they line up with state_q and never glitch.
  always_comb begin
    sel_hi   = 8'b1 << digit_cnt_d;
    sel_byte = SEG_ACTIVE_LOW ? ~sel_hi : sel_hi;
    word_d   = {seg_byte, sel_byte};
    ds_d     = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ?
               word_d[4'd15 - bit_cnt_d] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      digit_cnt_q <= '0;
      data_q      <= '0;
      dp_q        <= '0;
      lzb_q       <= 1'b0;
      blank_q     <= 1'b0;
      sh_cp_q     <= 1'b0;
      st_cp_q     <= 1'b0;
      ds_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      digit_cnt_q <= digit_cnt_d;
      data_q      <= data_d;
      dp_q        <= dp_d;
      lzb_q       <= lzb_d;
      blank_q     <= blank_d;
      sh_cp_q     <= (state_d == ST_SHIFT_HI);
      st_cp_q     <= (state_d == ST_LATCH);
      ds_q        <= ds_d;
      busy_q      <= (state_d inside {ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH});
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign sh_cp          = sh_cp_q;
  assign st_cp          = st_cp_q;
  assign ds             = ds_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: an 8-digit/div-4 active-low instance and a 4-digit/div-1
// active-high instance, with a pin-level monitor rebuilding the latched words.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(8)) a_if ();
  seg_scan_driver_if #(.DIGITS(4)) b_if ();

  logic   a_sh, a_st, a_ds, b_sh, b_st, b_ds;
  state_e a_state, b_state;

  seg_scan_driver #(.DIGITS(8), .SCLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(a_if),
    .sh_cp(a_sh), .st_cp(a_st), .ds(a_ds), .dbg_state_o(a_state)
  );

  seg_scan_driver #(.DIGITS(4), .SCLK_DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(b_if),
    .sh_cp(b_sh), .st_cp(b_st), .ds(b_ds), .dbg_state_o(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- pin monitor ----------------
  int cyc = 0;
  logic [15:0] a_sr = '0, b_sr = '0;
  logic [15:0] a_words[8];
  logic [15:0] b_words[4];
  int a_wcnt = 0, b_wcnt = 0, a_load_cyc = 0, b_load_cyc = 0;
  int a_fd_cyc = 0, b_fd_cyc = 0, a_fd_cnt = 0, b_fd_cnt = 0;
  int b_sh_last = 0, b_sh_period = 0;
  logic a_busy_p = 0, a_sh_p = 0, a_st_p = 0, b_busy_p = 0, b_sh_p = 0, b_st_p = 0;

  always @(negedge clk) begin
    cyc++;
    if (a_if.busy && !a_busy_p) begin a_load_cyc = cyc; a_wcnt = 0; a_fd_cnt = 0; end
    if (a_sh && !a_sh_p) a_sr = {a_sr[14:0], a_ds};
    if (a_st && !a_st_p) begin
      if (a_wcnt < 8) a_words[a_wcnt] = a_sr;
      a_wcnt++;
    end
    if (a_if.frame_done) begin a_fd_cnt++; a_fd_cyc = cyc; end
    if (b_if.busy && !b_busy_p) begin b_load_cyc = cyc; b_wcnt = 0; b_fd_cnt = 0; end
    if (b_sh && !b_sh_p) begin
      b_sr = {b_sr[14:0], b_ds};
      if (b_sh_last > 0) b_sh_period = cyc - b_sh_last;
      b_sh_last = cyc;
    end
    if (b_st && !b_st_p) begin
      if (b_wcnt < 4) b_words[b_wcnt] = b_sr;
      b_wcnt++;
    end
    if (b_if.frame_done) begin b_fd_cnt++; b_fd_cyc = cyc; end
    a_busy_p = a_if.busy; a_sh_p = a_sh; a_st_p = a_st;
    b_busy_p = b_if.busy; b_sh_p = b_sh; b_st_p = b_st;
  end

  // ---------------- driver / wait tasks ----------------
  task automatic wait_a_done();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (a_if.frame_done) begin ok = 1'b1; break; end
    end
    check("a_frame_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_b_done();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (b_if.frame_done) begin ok = 1'b1; break; end
    end
    check("b_frame_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic set_a(input logic [31:0] data, input logic [7:0] dp,
                       input logic lzb, input logic blank);
    a_if.data = data; a_if.dp_mask = dp; a_if.lzb_en = lzb; a_if.blank = blank;
  endtask

  // exp_words packs digit 7 in the top 16 bits down to digit 0 in the bottom.
  task automatic check_a_frame(input string name, input logic [127:0] exp_words);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_words[16*i +: 16]);
    check({name, "_word_count"}, 32'(a_wcnt), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_digit%0d", name, i), 32'(a_words[i]), 32'(exp_q.pop_front()));
    check({name, "_length"}, 32'(a_fd_cyc - a_load_cyc), 32'd1057);
    @(negedge clk); #1;
    check({name, "_done_one_cycle"}, 32'(a_if.frame_done), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    a_if.en = 1'b1;
    set_a(32'h1234_5678, 8'h00, 1'b0, 1'b0);
    b_if.en = 1'b1; b_if.data = 16'h9C3E; b_if.dp_mask = 4'b0100;
    b_if.lzb_en = 1'b0; b_if.blank = 1'b0;

    // Reset held with en=1: every output stays low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("a_reset_outputs_%0d", i),
            {27'd0, a_sh, a_st, a_ds, a_if.busy, a_if.frame_done}, 32'd0);
    end
    check("a_reset_state", 32'(a_state), 32'(ST_IDLE));

    @(negedge clk); rst_a = 1'b0;
    @(negedge clk); #1;
    check("a_busy_after_release", 32'(a_if.busy), 32'd1);
    check("a_state_load", 32'(a_state), 32'(ST_LOAD));

    // Frame 1 plain digits; frame 2 inputs change mid-frame 1.
    repeat (100) @(negedge clk);
    set_a(32'h0000_0A05, 8'h02, 1'b1, 1'b0);
    wait_a_done();
    check_a_frame("f1", {16'hF97F, 16'hA4BF, 16'hB0DF, 16'h99EF,
                         16'h92F7, 16'h82FB, 16'hF8FD, 16'h80FE});

    repeat (100) @(negedge clk);
    set_a(32'h0000_0000, 8'h00, 1'b1, 1'b0);
    wait_a_done();
    check_a_frame("f2_lzb_dp", {16'hFF7F, 16'hFFBF, 16'hFFDF, 16'hFFEF,
                                16'hFFF7, 16'h88FB, 16'h40FD, 16'h92FE});

    repeat (100) @(negedge clk);
    set_a(32'h1234_5678, 8'hFF, 1'b0, 1'b1);
    wait_a_done();
    check_a_frame("f3_all_zero", {16'hFF7F, 16'hFFBF, 16'hFFDF, 16'hFFEF,
                                  16'hFFF7, 16'hFFFB, 16'hFFFD, 16'hC0FE});

    // Frame 4 blanked; en drops while digit 3 is shifting.
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk); #1;
        if (a_wcnt == 3) begin ok = 1'b1; break; end
      end
      check("a_reached_digit3", 32'(ok), 32'd1);
    end
    a_if.en = 1'b0;
    wait_a_done();
    check_a_frame("f4_blank", {16'hFF7F, 16'hFFBF, 16'hFFDF, 16'hFFEF,
                               16'hFFF7, 16'hFFFB, 16'hFFFD, 16'hFFFE});
    repeat (50) @(negedge clk);
    #1;
    check("a_idle_after_en_drop", 32'(a_state), 32'(ST_IDLE));
    check("a_busy_low_idle", 32'(a_if.busy), 32'd0);
    check("a_single_done", 32'(a_fd_cnt), 32'd1);
    check("a_ds_low_idle", 32'(a_ds), 32'd0);

    // Small instance: 4 digits, divider 1, active-high pins.
    @(negedge clk); rst_b = 1'b0;
    wait_b_done();
    check("b_word_count", 32'(b_wcnt), 32'd4);
    check("b_digit0", 32'(b_words[0]), 32'h7901);
    check("b_digit1", 32'(b_words[1]), 32'h4F02);
    check("b_digit2_dp", 32'(b_words[2]), 32'hB904);
    check("b_digit3", 32'(b_words[3]), 32'h6F08);
    check("b_length", 32'(b_fd_cyc - b_load_cyc), 32'd133);
    check("b_sh_period", 32'(b_sh_period), 32'd2);

    // Asynchronous reset in the middle of a shift-high phase.
    b_if.data = 16'h0000; b_if.dp_mask = 4'b0000;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (b_state == ST_SHIFT_HI) begin ok = 1'b1; break; end
      end
      check("b_reached_shift_hi", 32'(ok), 32'd1);
    end
    check("b_sh_high_before_reset", 32'(b_sh), 32'd1);
    rst_b = 1'b1;
    #1;
    check("b_async_reset_outputs",
          {27'd0, b_sh, b_st, b_ds, b_if.busy, b_if.frame_done}, 32'd0);
    check("b_async_reset_state", 32'(b_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    wait_b_done();
    check("b_fresh_word_count", 32'(b_wcnt), 32'd4);
    check("b_fresh_digit0", 32'(b_words[0]), 32'h3F01);
    check("b_fresh_digit3", 32'(b_words[3]), 32'h3F08);
    check("b_fresh_length", 32'(b_fd_cyc - b_load_cyc), 32'd133);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
